// File: rtl/stream_pkg.sv
// ============================================================================
// stream_pkg : shared constants and state encodings for stream_arb_mux2
// Rev 1.0
// ============================================================================
`default_nettype none

package stream_pkg;
  localparam int DEFAULT_WIDTH = 8;

  localparam logic SRC_I0 = 1'b0;
  localparam logic SRC_I1 = 1'b1;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_e;
endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : combinational two-way round-robin grant with optional source lock
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import stream_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic prio_i,
  input  logic lock_i,
  input  logic lock_src_i,
  output logic gnt_valid_o,
  output logic gnt_idx_o
);

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = SRC_I0;
    if (lock_i) begin
      // A locked source owns the channel; the other side waits even with priority.
      gnt_idx_o   = lock_src_i;
      gnt_valid_o = (lock_src_i == SRC_I1) ? req1_i : req0_i;
    end else if (req0_i && req1_i) begin
      gnt_valid_o = 1'b1;
      gnt_idx_o   = prio_i;
    end else if (req0_i) begin
      gnt_valid_o = 1'b1;
      gnt_idx_o   = SRC_I0;
    end else if (req1_i) begin
      gnt_valid_o = 1'b1;
      gnt_idx_o   = SRC_I1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_arb_mux2.sv
// ============================================================================
// stream_arb_mux2 : two-input round-robin stream merger, registered output
// Optional packet lock (i0_last/i1_last) enabled by macro ARB_LOCK_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module stream_arb_mux2
  import stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ARB_LOCK_EN
  input  logic             i0_last,
  input  logic             i1_last,
`endif
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             s0
);

  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             s0_q, s0_d;
  prio_e            prio_q, prio_d;

  logic             load;
  logic             accept;
  logic             gnt_valid;
  logic             gnt_idx;
  logic             lock;
  logic             lock_src;

`ifdef ARB_LOCK_EN
  logic lock_q, lock_d;
  logic lock_src_q, lock_src_d;
  logic sel_last;

  assign lock     = lock_q;
  assign lock_src = lock_src_q;
  assign sel_last = (gnt_idx == SRC_I1) ? i1_last : i0_last;
`else
  assign lock     = 1'b0;
  assign lock_src = SRC_I0;
`endif

  rr_arb2 u_arb (
    .req0_i      (i0_valid),
    .req1_i      (i1_valid),
    .prio_i      (prio_q),
    .lock_i      (lock),
    .lock_src_i  (lock_src),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Slot is free or draining this cycle; readies never look at y_data.
  assign load     = ~y_valid_q | y_ready;
  assign accept   = load & gnt_valid;
  assign i0_ready = load & gnt_valid & (gnt_idx == SRC_I0);
  assign i1_ready = load & gnt_valid & (gnt_idx == SRC_I1);

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    s0_d      = s0_q;
    prio_d    = prio_q;
`ifdef ARB_LOCK_EN
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
`endif
    if (load) begin
      if (accept) begin
        y_valid_d = 1'b1;
        y_data_d  = (gnt_idx == SRC_I1) ? i1_data : i0_data;
        s0_d      = gnt_idx;
        prio_d    = (gnt_idx == SRC_I0) ? PRIO1 : PRIO0;
`ifdef ARB_LOCK_EN
        lock_d     = ~sel_last;
        lock_src_d = gnt_idx;
`endif
      end else begin
        y_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      s0_q      <= SRC_I0;
      prio_q    <= PRIO0;
`ifdef ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_src_q <= SRC_I0;
`endif
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      s0_q      <= s0_d;
      prio_q    <= prio_d;
`ifdef ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
`endif
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign s0      = s0_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_arb_mux2.sv
// ============================================================================
// tb_stream_arb_mux2 : directed self-checking bench for stream_arb_mux2
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stream_arb_mux2;

  logic       clk = 1'b0;
  logic       rst;
  logic       i0_valid, i1_valid;
  logic [7:0] i0_data, i1_data;
  logic       i0_ready, i1_ready;
  logic       y_valid;
  logic [7:0] y_data;
  logic       y_ready;
  logic       s0;
`ifdef ARB_LOCK_EN
  logic       i0_last, i1_last;
`endif

  int total = 0;
  int bad   = 0;

  stream_arb_mux2 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef ARB_LOCK_EN
    .i0_last  (i0_last),
    .i1_last  (i1_last),
`endif
    .i0_valid (i0_valid),
    .i0_data  (i0_data),
    .i0_ready (i0_ready),
    .i1_valid (i1_valid),
    .i1_data  (i1_data),
    .i1_ready (i1_ready),
    .y_valid  (y_valid),
    .y_data   (y_data),
    .y_ready  (y_ready),
    .s0       (s0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(v));
    chk({tag, ".y_data"},  32'(y_data),  32'(d));
    chk({tag, ".s0"},      32'(s0),      32'(s));
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".i0_ready"}, 32'(i0_ready), 32'(r0));
    chk({tag, ".i1_ready"}, 32'(i1_ready), 32'(r1));
  endtask

  logic [7:0] alt_data [6];
  logic       alt_src  [6];

  initial begin
    alt_data = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};
    alt_src  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; y_ready = 1'b0;
    i0_valid = 1'b0; i1_valid = 1'b0; i0_data = 8'h00; i1_data = 8'h00;
`ifdef ARB_LOCK_EN
    i0_last = 1'b1; i1_last = 1'b1;
`endif
    tick(); tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 8'h00, 1'b0);

    // Idle: nothing valid, so nothing granted and the slot stays empty.
    y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_rdy("idle", 1'b0, 1'b0);
      tick();
      chk_out("idle", 1'b0, 8'h00, 1'b0);
    end

    // Lone i0 word.
    i0_valid = 1'b1; i0_data = 8'hA5;
    #1; chk_rdy("lone_i0", 1'b1, 1'b0);
    tick(); chk_out("lone_i0", 1'b1, 8'hA5, 1'b0);

    // Lone i1 word; prio was PRIO1 and returns to PRIO0 afterwards.
    i0_valid = 1'b0; i1_valid = 1'b1; i1_data = 8'h5A;
    #1; chk_rdy("lone_i1", 1'b0, 1'b1);
    tick(); chk_out("lone_i1", 1'b1, 8'h5A, 1'b1);

    // Both valid: strict alternation starting from i0.
    i0_valid = 1'b1; i0_data = 8'h11; i1_valid = 1'b1; i1_data = 8'h22;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("alternate", 1'b1, alt_data[i], alt_src[i]);
    end

    // Load 33 from i0 (prio PRIO0 -> PRIO1), then stall downstream.
    i1_valid = 1'b0; i0_data = 8'h33;
    tick(); chk_out("load33", 1'b1, 8'h33, 1'b0);
    y_ready = 1'b0; i0_data = 8'h55; i1_valid = 1'b1; i1_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      #1; chk_rdy("stall", 1'b0, 1'b0);
      tick(); chk_out("stall", 1'b1, 8'h33, 1'b0);
    end
    // Drain and fill on the same edge; prio favours i1.
    y_ready = 1'b1;
    #1; chk_rdy("drain_fill", 1'b0, 1'b1);
    tick(); chk_out("drain_fill", 1'b1, 8'h66, 1'b1);

    // Hold 44 from i0, then reset mid-operation with both valid.
    i0_data = 8'h44;
    tick(); chk_out("load44", 1'b1, 8'h44, 1'b0);
    y_ready = 1'b0; rst = 1'b1;
    tick(); chk_out("mid_reset", 1'b0, 8'h00, 1'b0);
    rst = 1'b0; y_ready = 1'b1; i0_data = 8'h77; i1_data = 8'h88;
    tick(); chk_out("post_reset0", 1'b1, 8'h77, 1'b0);
    tick(); chk_out("post_reset1", 1'b1, 8'h88, 1'b1);

    // Nothing accepted: valid drops, data and s0 hold.
    i0_valid = 1'b0; i1_valid = 1'b0;
    tick(); chk_out("bubble", 1'b0, 8'h88, 1'b1);

`ifdef ARB_LOCK_EN
    // i0 packet of three words locks out i1 even when i1 holds priority.
    i1_valid = 1'b1; i1_data = 8'hD1; i1_last = 1'b1;
    i0_valid = 1'b1;
    i0_data = 8'hC1; i0_last = 1'b0;
    #1; chk_rdy("pkt0", 1'b1, 1'b0);
    tick(); chk_out("pkt0", 1'b1, 8'hC1, 1'b0);
    i0_data = 8'hC2; i0_last = 1'b0;
    #1; chk_rdy("pkt1", 1'b1, 1'b0);
    tick(); chk_out("pkt1", 1'b1, 8'hC2, 1'b0);
    i0_data = 8'hC3; i0_last = 1'b1;
    #1; chk_rdy("pkt2", 1'b1, 1'b0);
    tick(); chk_out("pkt2", 1'b1, 8'hC3, 1'b0);
    i0_valid = 1'b0;
    #1; chk_rdy("pkt_i1", 1'b0, 1'b1);
    tick(); chk_out("pkt_i1", 1'b1, 8'hD1, 1'b1);
    i1_valid = 1'b0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
